// File: rtl/wb_host_initiator_if.sv
// Command/response port plus Wishbone classic master signals of the host initiator.
// The initiator connects through "master"; a bench or bridge drives the opposite "slave" side.
interface wb_host_initiator_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [11:0] cmd_addr;
    logic [15:0] cmd_wdata;
    logic [1:0]  cmd_sel;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack_i;

    modport master (
        input  cmd_valid, cmd_we, cmd_addr, cmd_wdata, cmd_sel, wbm_dat_i, wbm_ack_i,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
               wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o
    );

    modport slave (
        output cmd_valid, cmd_we, cmd_addr, cmd_wdata, cmd_sel, wbm_dat_i, wbm_ack_i,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
               wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o
    );
endinterface

// File: rtl/wb_host_initiator.sv
// Single-cycle Wishbone classic initiator: one command in, one bus cycle out, one response strobe back.
// Cycles that see no ack within TIMEOUT strobe cycles are aborted with an error response.
module wb_host_initiator #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic                clk,
    input  logic                rst,
    wb_host_initiator_if.master bus
);
    typedef enum logic {IDLE = 1'b0, BUS = 1'b1} state_t;

    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic        cyc_q, cyc_d;
    logic        we_q, we_d;
    logic [11:0] adr_q, adr_d;
    logic [15:0] dat_q, dat_d;
    logic [1:0]  sel_q, sel_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [15:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;

    logic accept;
    logic ack_hit;
    logic expire;
    logic unused_dat_hi;

    assign accept  = bus.cmd_valid && (state_q == IDLE);
    assign ack_hit = (state_q == BUS) && bus.wbm_ack_i;
    // Ack has priority over expiry when both land in the same cycle.
    assign expire  = (state_q == BUS) && !bus.wbm_ack_i && (TIMEOUT != 0) && (cnt_q == TO_LAST);
    assign unused_dat_hi = ^bus.wbm_dat_i[31:16];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= '0;
            dat_q       <= '0;
            sel_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cyc_q       <= cyc_d;
            we_q        <= we_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            sel_q       <= sel_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = BUS;
            BUS:     if (ack_hit || expire) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d       = cnt_q;
        cyc_d       = cyc_q;
        we_d        = we_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        sel_d       = sel_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        if (accept) begin
            cyc_d = 1'b1;
            we_d  = bus.cmd_we;
            adr_d = bus.cmd_addr;
            dat_d = bus.cmd_wdata;
            sel_d = bus.cmd_sel;
            cnt_d = '0;
        end else if (ack_hit) begin
            cyc_d       = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b0;
            rsp_rdata_d = we_q ? 16'h0000 : bus.wbm_dat_i[15:0];
        end else if (expire) begin
            cyc_d       = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = 16'h0000;
        end else if (state_q == BUS) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // cyc and stb share one register so they can never diverge.
    assign bus.cmd_ready = (state_q == IDLE);
    assign bus.wbm_cyc_o = cyc_q;
    assign bus.wbm_stb_o = cyc_q;
    assign bus.wbm_we_o  = we_q;
    assign bus.wbm_adr_o = {20'b0, adr_q};
    assign bus.wbm_dat_o = {16'b0, dat_q};
    assign bus.wbm_sel_o = {2'b0, sel_q};
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_wb_host_initiator.sv
// Directed bench for wb_host_initiator with TIMEOUT = 4; every cycle step lands 1 ns after the rising edge.
module tb_wb_host_initiator;
    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    wb_host_initiator_if bus ();

    wb_host_initiator #(.TIMEOUT(4), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-18s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic cmd(input logic we, input logic [11:0] addr, input logic [15:0] wdata, input logic [1:0] sel);
        bus.cmd_valid = 1'b1;
        bus.cmd_we    = we;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = wdata;
        bus.cmd_sel   = sel;
    endtask

    initial begin
        rst           = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_we    = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.cmd_sel   = '0;
        bus.wbm_dat_i = '0;
        bus.wbm_ack_i = 1'b0;
        step();
        step();
        chk("rst_cyc",   {31'b0, bus.wbm_cyc_o}, 32'd0);
        chk("rst_stb",   {31'b0, bus.wbm_stb_o}, 32'd0);
        chk("rst_adr",   bus.wbm_adr_o, 32'd0);
        chk("rst_dat",   bus.wbm_dat_o, 32'd0);
        chk("rst_rsp",   {15'b0, bus.rsp_valid, bus.rsp_rdata}, 32'd0);
        rst = 1'b0;
        step();
        chk("rst_ready", {31'b0, bus.cmd_ready}, 32'd1);

        // Write, zero wait states
        cmd(1'b1, 12'h0A5, 16'hBEEF, 2'b11);
        step();
        bus.cmd_valid = 1'b0;
        chk("wr_stb",    {31'b0, bus.wbm_stb_o}, 32'd1);
        chk("wr_cyc",    {31'b0, bus.wbm_cyc_o}, 32'd1);
        chk("wr_adr",    bus.wbm_adr_o, 32'h0000_00A5);
        chk("wr_dat",    bus.wbm_dat_o, 32'h0000_BEEF);
        chk("wr_sel",    {28'b0, bus.wbm_sel_o}, 32'h3);
        chk("wr_we",     {31'b0, bus.wbm_we_o}, 32'd1);
        chk("wr_ready",  {31'b0, bus.cmd_ready}, 32'd0);
        bus.wbm_ack_i = 1'b1;
        step();
        bus.wbm_ack_i = 1'b0;
        chk("wr_stb_end", {31'b0, bus.wbm_stb_o}, 32'd0);
        chk("wr_rsp",    {14'b0, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}, 32'h0002_0000);
        chk("wr_ready2", {31'b0, bus.cmd_ready}, 32'd1);
        step();
        chk("wr_rsp_1cyc", {31'b0, bus.rsp_valid}, 32'd0);

        // Read, three wait states
        cmd(1'b0, 12'hFFF, 16'h5555, 2'b01);
        step();
        bus.cmd_valid = 1'b0;
        chk("rd_we",     {31'b0, bus.wbm_we_o}, 32'd0);
        chk("rd_adr",    bus.wbm_adr_o, 32'h0000_0FFF);
        for (int c = 1; c <= 3; c++) begin
            chk($sformatf("rd_stb_c%0d", c), {30'b0, bus.wbm_stb_o, bus.rsp_valid}, 32'h2);
            step();
        end
        chk("rd_stb_c4", {31'b0, bus.wbm_stb_o}, 32'd1);
        bus.wbm_ack_i = 1'b1;
        bus.wbm_dat_i = 32'h1234_ABCD;
        step();
        bus.wbm_ack_i = 1'b0;
        bus.wbm_dat_i = 32'h0;
        chk("rd_stb_c5", {31'b0, bus.wbm_stb_o}, 32'd0);
        chk("rd_rsp",    {14'b0, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}, 32'h0002_ABCD);
        step();
        chk("rd_hold",   {14'b0, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}, 32'h0000_ABCD);

        // Timeout, no ack at all
        cmd(1'b0, 12'h123, 16'h0, 2'b11);
        step();
        bus.cmd_valid = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            chk($sformatf("to_stb_c%0d", c), {30'b0, bus.wbm_stb_o, bus.rsp_valid}, 32'h2);
            step();
        end
        chk("to_stb_c5", {31'b0, bus.wbm_stb_o}, 32'd0);
        chk("to_rsp",    {14'b0, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}, 32'h0003_0000);
        chk("to_ready",  {31'b0, bus.cmd_ready}, 32'd1);
        step();

        // Ack in the last permitted cycle beats the timeout
        cmd(1'b0, 12'h321, 16'h0, 2'b10);
        step();
        bus.cmd_valid = 1'b0;
        step();
        step();
        step();
        chk("col_stb_c4", {31'b0, bus.wbm_stb_o}, 32'd1);
        bus.wbm_ack_i = 1'b1;
        bus.wbm_dat_i = 32'hFFFF_5A5A;
        step();
        bus.wbm_ack_i = 1'b0;
        chk("col_rsp",   {14'b0, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}, 32'h0002_5A5A);
        step();

        // Back-to-back with cmd inputs changing during BUS
        cmd(1'b1, 12'h111, 16'h1111, 2'b01);
        step();
        cmd(1'b1, 12'h222, 16'h2222, 2'b10);
        chk("b2b_a_adr", bus.wbm_adr_o, 32'h0000_0111);
        step();
        chk("b2b_a_hold", bus.wbm_adr_o, 32'h0000_0111);
        chk("b2b_a_dhold", bus.wbm_dat_o, 32'h0000_1111);
        bus.wbm_ack_i = 1'b1;
        step();
        bus.wbm_ack_i = 1'b0;
        chk("b2b_a_rsp", {30'b0, bus.rsp_valid, bus.cmd_ready}, 32'h3);
        step();
        bus.cmd_valid = 1'b0;
        chk("b2b_b_stb", {31'b0, bus.wbm_stb_o}, 32'd1);
        chk("b2b_b_adr", bus.wbm_adr_o, 32'h0000_0222);
        chk("b2b_b_sel", {28'b0, bus.wbm_sel_o}, 32'h2);
        bus.wbm_ack_i = 1'b1;
        step();
        bus.wbm_ack_i = 1'b0;
        chk("b2b_b_rsp", {14'b0, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}, 32'h0002_0000);
        step();
        chk("b2b_idle",  {30'b0, bus.wbm_stb_o, bus.cmd_ready}, 32'h1);

        // Reset in cycle 2 of a waiting read, then a stray ack
        cmd(1'b0, 12'h0F0, 16'h0, 2'b11);
        step();
        bus.cmd_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mrst_bus",  {29'b0, bus.wbm_cyc_o, bus.wbm_stb_o, bus.rsp_valid}, 32'h0);
        chk("mrst_ready", {31'b0, bus.cmd_ready}, 32'd1);
        chk("mrst_adr",  bus.wbm_adr_o, 32'h0);
        bus.wbm_ack_i = 1'b1;
        bus.wbm_dat_i = 32'hDEAD_BEEF;
        step();
        bus.wbm_ack_i = 1'b0;
        chk("stray_ack", {15'b0, bus.rsp_valid, bus.rsp_rdata}, 32'h0);
        step();
        chk("stray_ack2", {30'b0, bus.rsp_valid, bus.wbm_stb_o}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/wb_host_initiator.md
# wb_host_initiator

Wishbone classic initiator that issues single read/write cycles toward the SoC's 16-bit program/data memory window. It drives `wbs_*` on the responder side of the user project wrapper. The block accepts one command at a time from a valid/ready request port, runs exactly one Wishbone cycle, and returns read data or a timeout error on a one-cycle response strobe. It is the on-chip counterpart used for bring-up, loader, and self-test paths.

## Interface
Parameters:
- `TIMEOUT`, default 255: number of `stb` cycles without `ack` before the cycle is aborted. Range 1..255. A value of 0 disables the timeout.
- `CNT_W`, default 8: width of the timeout counter. Must satisfy 2^CNT_W > TIMEOUT.

Ports:
- `clk`  in  1: single clock.
- `rst`  in  1: synchronous, active-high reset.
- `cmd_valid`  in  1: command request.
- `cmd_ready`  out  1: block can accept a command.
- `cmd_we`  in  1: 1 = write, 0 = read.
- `cmd_addr`  in  12: word address.
- `cmd_wdata`  in  16: write data.
- `cmd_sel`  in  2: byte-lane mask.
- `rsp_valid`  out  1: one-cycle response strobe.
- `rsp_rdata`  out  16: read data. 0 for writes and errors.
- `rsp_err`  out  1: timeout occurred. Qualified by `rsp_valid`.
- `wbm_cyc_o`, `wbm_stb_o`, `wbm_we_o`  out  1 each: Wishbone controls.
- `wbm_adr_o`  out  32: `{20'b0, addr}`.
- `wbm_dat_o`  out  32: `{16'b0, wdata}`.
- `wbm_sel_o`  out  4: `{2'b0, sel}`.
- `wbm_dat_i`  in  32: read data. Only `[15:0]` is used.
- `wbm_ack_i`  in  1: cycle acknowledge.

## Operation
- The FSM has two states: IDLE and BUS. All outputs are registered except `cmd_ready`.
- `cmd_ready = (state == IDLE)`. A command is accepted when `cmd_valid && cmd_ready`.
- On accept:
  - Latch `we`, `addr`, `wdata` and `sel` into the Wishbone output registers.
  - Set `cyc` and `stb` to 1.
  - Clear the timeout counter.
  - Go to BUS.
- While in BUS, the address, data, sel and we outputs are held stable. Changes on the `cmd_*` inputs are ignored.
- BUS with `wbm_ack_i = 1`:
  - Next edge: `cyc = stb = 0`, state goes to IDLE.
  - `rsp_valid = 1` and `rsp_err = 0`.
  - `rsp_rdata = wbm_dat_i[15:0]` for a read, or 0 for a write.
- BUS without ack:
  - The counter increments.
  - If `TIMEOUT != 0` and the counter equals `TIMEOUT - 1`, the cycle aborts on the next edge: `cyc = stb = 0`, `rsp_valid = 1`, `rsp_err = 1`, `rsp_rdata = 0`, state goes to IDLE.
- `rsp_valid` is high for exactly one cycle. `rsp_err` and `rsp_rdata` hold their value until the next response. There is no response backpressure.
- `wbm_ack_i` outside BUS is ignored. No response is generated.
- If ack and timeout expiry fall in the same cycle, the ack wins (normal response, `rsp_err = 0`).
- `wbm_we_o` is forced to 0 and `wbm_sel_o` is left as latched for reads. The responder ignores sel on reads.

## Timing
- Reset: at the `rst` edge, state goes to IDLE. Every registered output clears: `cyc`, `stb`, `we`, `adr`, `dat_o`, `sel`, `rsp_valid`, `rsp_rdata`, `rsp_err` are all 0.
- `cmd_ready` is 1 in the cycle after reset.
- Reset mid-cycle aborts the transfer immediately, with no response pulse.
- Cycle numbering, with accept at cycle 0:
  - Cycles 1..n: `stb` high. The responder acks at cycle n.
  - Cycle n+1: `rsp_valid` is 1 and `cmd_ready` is 1.
- Latency from accept to response is 1 + (wait states + 1) cycles. The minimum is 2 (ack in cycle 1).
- Back-to-back commands: a new command can be accepted in the response cycle. Best-case throughput is one transfer per 2 cycles.
- Timeout: with no ack, `stb` is high for exactly `TIMEOUT` cycles (cycles 1..TIMEOUT). The error response appears in cycle TIMEOUT+1.
- `cyc` and `stb` always rise and fall together. There are no bursts and no pipelined cycles.

## Test plan
- **Write:** `cmd` with `we=1`, `addr=0x0A5`, `wdata=0xBEEF`, `sel=2'b11`; ack after 0 waits.
  - Required: `adr = 0x000000A5`, `dat_o = 0x0000BEEF`, `sel = 4'b0011`, `we = 1`, all for exactly 1 cycle.
  - Required: `rsp_valid` at cycle 2 with `rsp_err = 0` and `rsp_rdata = 0`.
- **Read with wait states:** `we=0`, `addr=0xFFF`; ack after 3 waits with `dat_i = 0x1234ABCD`.
  - Required: `stb` high for 4 cycles.
  - Required: `rsp_rdata = 0xABCD` with `rsp_err = 0` at cycle 5.
- **Timeout:** `TIMEOUT = 4`, never ack.
  - Required: `stb` high for cycles 1..4, low at cycle 5.
  - Required: `rsp_valid = 1`, `rsp_err = 1`, `rsp_rdata = 0` at cycle 5.
- **Ack/timeout collision:** `TIMEOUT = 4`, ack in cycle 4.
  - Required: normal response at cycle 5 with `rsp_err = 0`.
- **Back-to-back:** hold `cmd_valid` high with two commands.
  - Required: the second command is accepted in the first command's response cycle.
  - Required: the second command's `stb` appears 1 cycle later.
  - Required: `cmd_inputs` changing during BUS do not alter `adr`.
- **Reset mid-operation:** assert `rst` in cycle 2 of a waiting read.
  - Required: next cycle `cyc = stb = rsp_valid = 0`, `cmd_ready = 1`.
  - Required: a stray `ack_i` after reset produces no response.
